// File: rtl/command_interpreter_if.sv
// Host-side UART byte stream, processor bus and core reset between the interpreter and its environment.
// master = interpreter, slave = UART/bus/core side.
interface command_interpreter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  core_reset;
  logic                  bus_req;
  logic                  bus_we;
  logic                  bus_space;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;
  logic                  busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
    output rx_ready, tx_data, tx_valid, core_reset, bus_req, bus_we, bus_space,
           bus_addr, bus_wdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
    input  rx_ready, tx_data, tx_valid, core_reset, bus_req, bus_we, bus_space,
           bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/command_interpreter.sv
// Parses framed host commands into bus accesses / core reset pulses and streams response bytes back.
// Bus request starts the cycle after the last frame byte; rx is stalled while a command is in flight, tx waits on tx_ready.
module command_interpreter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset,
  command_interpreter_if.master ci
);

  localparam int DB = DATA_WIDTH / 8;
  localparam int AB = ADDR_WIDTH / 8;
  localparam int BW = 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [BW-1:0] ADDR_LAST = BW'(AB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DB - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);

  localparam logic [7:0] RSP_OK   = 8'h55;
  localparam logic [7:0] RSP_ERR  = 8'hEE;
  localparam logic [7:0] RSP_PING = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, CORE_RST, SEND
  } state_t;

  state_t                state_q;
  logic [BW-1:0]         byte_cnt_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic [RW-1:0]         rst_cnt_q;
  logic                  rx_ready_q;
  logic                  tx_valid_q;
  logic                  core_reset_q;
  logic                  bus_req_q;
  logic                  we_q;
  logic                  space_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  resp_multi_q;

  logic rx_fire;
  logic tx_fire;
  assign rx_fire = ci.rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & ci.tx_ready;

  // Single-byte responses sit in the top byte so tx_data always reads the MSB.
  function automatic logic [DATA_WIDTH-1:0] top_byte(input logic [7:0] b);
    return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      rx_ready_q   <= 1'b1;
      tx_valid_q   <= 1'b0;
      core_reset_q <= 1'b0;
      bus_req_q    <= 1'b0;
      we_q         <= 1'b0;
      space_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      resp_multi_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            byte_cnt_q   <= '0;
            resp_multi_q <= 1'b0;
            case (ci.rx_data)
              8'h01: begin
                state_q      <= CORE_RST;
                rx_ready_q   <= 1'b0;
                core_reset_q <= 1'b1;
                rst_cnt_q    <= '0;
              end
              8'h02, 8'h03, 8'h04, 8'h05: begin
                // Opcode bit 0 selects write, bit 2 selects the register file.
                state_q <= GET_ADDR;
                we_q    <= ci.rx_data[0];
                space_q <= ci.rx_data[2];
              end
              8'h06: begin
                state_q    <= SEND;
                rx_ready_q <= 1'b0;
                tx_valid_q <= 1'b1;
                resp_q     <= top_byte(RSP_PING);
              end
              default: begin
                state_q    <= SEND;
                rx_ready_q <= 1'b0;
                tx_valid_q <= 1'b1;
                resp_q     <= top_byte(RSP_ERR);
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_fire) begin
            addr_q <= (addr_q << 8) | ADDR_WIDTH'(ci.rx_data);
            if (byte_cnt_q == ADDR_LAST) begin
              byte_cnt_q <= '0;
              if (we_q) begin
                state_q <= GET_DATA;
              end else begin
                state_q    <= BUS;
                rx_ready_q <= 1'b0;
                bus_req_q  <= 1'b1;
                tmo_cnt_q  <= '0;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            wdata_q <= (wdata_q << 8) | DATA_WIDTH'(ci.rx_data);
            if (byte_cnt_q == DATA_LAST) begin
              byte_cnt_q <= '0;
              state_q    <= BUS;
              rx_ready_q <= 1'b0;
              bus_req_q  <= 1'b1;
              tmo_cnt_q  <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        BUS: begin
          // Ack is checked first so an ack in the last allowed cycle still completes.
          if (ci.bus_ack) begin
            bus_req_q    <= 1'b0;
            state_q      <= SEND;
            tx_valid_q   <= 1'b1;
            byte_cnt_q   <= '0;
            resp_multi_q <= ~we_q;
            resp_q       <= we_q ? top_byte(RSP_OK) : ci.bus_rdata;
          end else if (tmo_cnt_q == TMO_LAST) begin
            bus_req_q  <= 1'b0;
            state_q    <= SEND;
            tx_valid_q <= 1'b1;
            resp_q     <= top_byte(RSP_ERR);
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        CORE_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            core_reset_q <= 1'b0;
            state_q      <= SEND;
            tx_valid_q   <= 1'b1;
            resp_q       <= top_byte(RSP_OK);
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        SEND: begin
          if (tx_fire) begin
            if (!resp_multi_q || byte_cnt_q == DATA_LAST) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              resp_q     <= resp_q << 8;
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ci.rx_ready   = rx_ready_q;
  assign ci.tx_valid   = tx_valid_q;
  assign ci.tx_data    = resp_q[DATA_WIDTH-1 -: 8];
  // The processor leaves reset in the same cycle the interpreter is reset.
  assign ci.core_reset = core_reset_q & ~reset;
  assign ci.bus_req    = bus_req_q;
  assign ci.bus_we     = we_q;
  assign ci.bus_space  = space_q;
  assign ci.bus_addr   = addr_q;
  assign ci.bus_wdata  = wdata_q;
  assign ci.busy       = (state_q != IDLE);

endmodule
